// File: rtl/tr_sched_if.sv
// Valid/ready stream interface used for the scheduler's data and burst-length channels.
interface dti #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/tr_sched.sv
// Two-requester round-robin burst scheduler: grants dout to one requester for a
// posted number of eot-framed transactions, tagging beats with id and burst end.
module tr_sched #(
    parameter int W_DATA = 16,
    parameter int W_CNT  = 16
) (
    input  logic    clk,
    input  logic    rst,
    dti.consumer    din0,
    dti.consumer    cfg0,
    dti.consumer    din1,
    dti.consumer    cfg1,
    dti.producer    dout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic               sel, sel_nxt;
    logic               prio, prio_nxt;
    logic [W_CNT-1:0]   lim, lim_nxt;
    logic [W_CNT-1:0]   cnt, cnt_nxt;

    logic               pick;
    logic [W_CNT-1:0]   pick_len;
    logic [W_CNT-1:0]   lim_m1;
    logic [W_DATA:0]    sel_data;
    logic               sel_valid;
    logic               last;
    logic               hs;

    // Both cfg valid: preferred requester wins; otherwise whichever is posting.
    assign pick      = (cfg0.valid && cfg1.valid) ? prio : cfg1.valid;
    assign pick_len  = pick ? cfg1.data : cfg0.data;
    assign lim_m1    = lim - 1'b1;
    assign last      = (cnt == lim_m1);
    assign sel_data  = sel ? din1.data : din0.data;
    assign sel_valid = sel ? din1.valid : din0.valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            prio  <= 1'b0;
            lim   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            prio  <= prio_nxt;
            lim   <= lim_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        prio_nxt   = prio;
        lim_nxt    = lim;
        cnt_nxt    = cnt;
        hs         = 1'b0;
        cfg0.ready = 1'b0;
        cfg1.ready = 1'b0;
        din0.ready = 1'b0;
        din1.ready = 1'b0;
        dout.valid = 1'b0;
        dout.data  = '0;
        unique case (state)
            IDLE: begin
                if (cfg0.valid || cfg1.valid) begin
                    // Gated by rst so no cfg is consumed while reset is held.
                    cfg0.ready = rst && !pick;
                    cfg1.ready = rst && pick;
                    lim_nxt    = pick_len;
                    sel_nxt    = pick;
                    cnt_nxt    = '0;
                    if (pick_len != '0) begin
                        state_nxt = BUSY;
                    end else begin
                        prio_nxt = ~pick;
                    end
                end
            end
            BUSY: begin
                dout.valid = sel_valid;
                dout.data  = {sel, last, sel_data};
                din0.ready = !sel && dout.ready;
                din1.ready = sel && dout.ready;
                hs         = sel_valid && dout.ready;
                if (hs && sel_data[W_DATA]) begin
                    if (last) begin
                        cnt_nxt   = '0;
                        prio_nxt  = ~sel;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tr_sched.sv
// Scoreboard bench for tr_sched: queue-level arbitration model, randomized drivers.
module tb_tr_sched;
    localparam int WD = 16;
    localparam int WC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dti #(.W(WD+1)) din0 ();
    dti #(.W(WC))   cfg0 ();
    dti #(.W(WD+1)) din1 ();
    dti #(.W(WC))   cfg1 ();
    dti #(.W(WD+3)) dout ();

    tr_sched #(.W_DATA(WD), .W_CNT(WC)) dut (
        .clk  (clk),
        .rst  (rst),
        .din0 (din0),
        .cfg0 (cfg0),
        .din1 (din1),
        .cfg1 (cfg1),
        .dout (dout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int            cq0[$];
    int            cq1[$];
    logic [WD:0]   bq0[$];
    logic [WD:0]   bq1[$];
    logic [WD+2:0] exp_q[$];
    logic          prio_m = 1'b0;
    bit            mon_en = 1'b0;
    int            cfg_hs0;
    int            cfg_hs1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add_beat(input int r, input logic eot, input logic [WD-1:0] p);
        if (r == 0) bq0.push_back({eot, p});
        else        bq1.push_back({eot, p});
    endtask

    task automatic add_txn(input int r, input int nbeats);
        for (int i = 0; i < nbeats; i++)
            add_beat(r, (i == nbeats - 1), WD'($urandom));
    endtask

    task automatic add_burst(input int r, input int len, input int max_beats);
        if (r == 0) cq0.push_back(len);
        else        cq1.push_back(len);
        for (int t = 0; t < len; t++)
            add_txn(r, $urandom_range(1, max_beats));
    endtask

    // Reference: replay arbitration over the posted burst lists, all cfgs pending.
    task automatic build_expected();
        int          c0[$];
        int          c1[$];
        logic [WD:0] b0[$];
        logic [WD:0] b1[$];
        int          l;
        logic        x;
        logic [WD:0] b;
        c0 = cq0; c1 = cq1; b0 = bq0; b1 = bq1;
        while (c0.size() > 0 || c1.size() > 0) begin
            if (c0.size() > 0 && c1.size() > 0) x = prio_m;
            else                                x = (c1.size() > 0);
            if (x) l = c1.pop_front();
            else   l = c0.pop_front();
            for (int t = 0; t < l; t++) begin
                do begin
                    if (x) begin
                        if (b1.size() == 0) break;
                        b = b1.pop_front();
                    end else begin
                        if (b0.size() == 0) break;
                        b = b0.pop_front();
                    end
                    exp_q.push_back({x, (t == l - 1), b});
                end while (!b[WD]);
            end
            prio_m = ~x;
        end
    endtask

    task automatic drive_idle();
        cfg0.valid = 1'b0; cfg0.data = '0;
        cfg1.valid = 1'b0; cfg1.data = '0;
        din0.valid = 1'b0; din0.data = '0;
        din1.valid = 1'b0; din1.data = '0;
        dout.ready = 1'b0;
    endtask

    task automatic run_round(input int rdy_pct, input int vld_pct);
        bit h0 = 1'b0;
        bit h1 = 1'b0;
        int cyc = 0;
        build_expected();
        cfg_hs0 = 0;
        cfg_hs1 = 0;
        forever begin
            @(negedge clk);
            if (cq0.size() == 0 && cq1.size() == 0 && bq0.size() == 0 &&
                bq1.size() == 0 && exp_q.size() == 0) break;
            if (cyc >= 4000) begin
                n_tests++;
                n_fail++;
                $display("FAIL round_timeout: got %0d pending beats expected 0", exp_q.size());
                exp_q.delete(); cq0.delete(); cq1.delete(); bq0.delete(); bq1.delete();
                break;
            end
            cyc++;
            dout.ready = ($urandom_range(0, 99) < rdy_pct);
            cfg0.valid = (cq0.size() > 0);
            cfg0.data  = (cq0.size() > 0) ? WC'(cq0[0]) : '0;
            cfg1.valid = (cq1.size() > 0);
            cfg1.data  = (cq1.size() > 0) ? WC'(cq1[0]) : '0;
            if (!h0) h0 = (bq0.size() > 0) && ($urandom_range(0, 99) < vld_pct);
            if (!h1) h1 = (bq1.size() > 0) && ($urandom_range(0, 99) < vld_pct);
            din0.valid = h0;
            din0.data  = h0 ? bq0[0] : '0;
            din1.valid = h1;
            din1.data  = h1 ? bq1[0] : '0;
            #1;
            if (cfg0.valid && cfg0.ready) begin void'(cq0.pop_front()); cfg_hs0++; end
            if (cfg1.valid && cfg1.ready) begin void'(cq1.pop_front()); cfg_hs1++; end
            if (din0.valid && din0.ready) begin void'(bq0.pop_front()); h0 = 1'b0; end
            if (din1.valid && din1.ready) begin void'(bq1.pop_front()); h1 = 1'b0; end
        end
        drive_idle();
    endtask

    // Monitor: pops the scoreboard on every dout handshake, plus protocol checks.
    initial begin
        logic          prev_stall = 1'b0;
        logic          prev_last  = 1'b0;
        logic [WD+2:0] prev_data  = '0;
        logic [WD+2:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                prev_stall = 1'b0;
                prev_last  = 1'b0;
                continue;
            end
            n_tests++;
            if (cfg0.ready && cfg1.ready) begin
                n_fail++;
                $display("FAIL cfg_ready_overlap: got 11 expected at most one ready");
            end
            if (prev_last)  check("burst_bubble", dout.valid, 1'b0);
            if (prev_stall) begin
                check("stall_valid", dout.valid, 1'b1);
                check("stall_data", dout.data, prev_data);
            end
            if (dout.valid && dout.ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected no beat", dout.data);
                end else begin
                    e = exp_q.pop_front();
                    check("dout_beat", dout.data, e);
                end
            end
            prev_stall = dout.valid && !dout.ready;
            prev_data  = dout.data;
            prev_last  = dout.valid && dout.ready && dout.data[WD+1] && dout.data[WD];
        end
    end

    initial begin
        int k;
        bit cfg_pending;
        drive_idle();
        cfg0.valid = 1'b1; cfg0.data = 4'd1;
        cfg1.valid = 1'b1; cfg1.data = 4'd1;
        #12;
        check("rst_dout_valid", dout.valid, 1'b0);
        check("rst_cfg0_ready", cfg0.ready, 1'b0);
        check("rst_cfg1_ready", cfg1.ready, 1'b0);
        check("rst_din0_ready", din0.ready, 1'b0);
        check("rst_din1_ready", din1.ready, 1'b0);
        @(negedge clk);
        drive_idle();
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single burst of two transactions from requester 0.
        add_beat(0, 1'b0, 16'h00A1); add_beat(0, 1'b0, 16'h00A2); add_beat(0, 1'b1, 16'h00A3);
        add_beat(0, 1'b0, 16'h00B1); add_beat(0, 1'b1, 16'h00B2);
        cq0.push_back(2);
        run_round(100, 100);
        check("single_cfg0_hs", cfg_hs0, 1);

        // Fairness: both post length-1 bursts continuously.
        for (int i = 0; i < 4; i++) begin
            add_burst(0, 1, 1);
            add_burst(1, 1, 1);
        end
        run_round(100, 100);
        check("fair_cfg0_hs", cfg_hs0, 4);
        check("fair_cfg1_hs", cfg_hs1, 4);

        // Zero-length cfg1 after a grant to 0 flips preference back to 0.
        add_burst(0, 1, 2);
        run_round(100, 100);
        cq1.push_back(0);
        run_round(100, 100);
        check("zero_cfg1_hs", cfg_hs1, 1);
        add_burst(0, 1, 1);
        add_burst(1, 1, 1);
        run_round(100, 100);

        // Maximum burst length for a 4-bit counter.
        add_burst(0, 15, 1);
        run_round(80, 80);
        check("max_cfg0_hs", cfg_hs0, 1);

        // Heavy backpressure.
        add_burst(0, 3, 3);
        add_burst(1, 2, 3);
        run_round(40, 100);

        for (int r = 0; r < 8; r++) begin
            for (int q = 0; q < 2; q++)
                for (int n = $urandom_range(0, 3); n > 0; n--)
                    add_burst(q, $urandom_range(0, 5), 3);
            run_round($urandom_range(40, 100), $urandom_range(40, 100));
        end

        // Reset mid-burst: 2 of 4 transactions from requester 0 done.
        @(negedge clk);
        mon_en = 1'b0;
        cfg_pending = 1'b1;
        k = 0;
        for (int c = 0; c < 50 && k < 2; c++) begin
            @(negedge clk);
            dout.ready = 1'b1;
            cfg0.valid = cfg_pending;
            cfg0.data  = 4'd4;
            din0.valid = 1'b1;
            din0.data  = {1'b1, 16'h00C0 + 16'(k)};
            #1;
            if (cfg0.valid && cfg0.ready) cfg_pending = 1'b0;
            if (din0.valid && din0.ready) k++;
        end
        check("rst_test_progress", k, 2);
        @(negedge clk);
        din0.valid = 1'b1;
        cfg0.valid = 1'b1; cfg0.data = 4'd4;
        cfg1.valid = 1'b1; cfg1.data = 4'd3;
        dout.ready = 1'b1;
        #1;
        check("pre_rst_busy_valid", dout.valid, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_dout_valid", dout.valid, 1'b0);
        check("async_rst_din0_ready", din0.ready, 1'b0);
        check("async_rst_din1_ready", din1.ready, 1'b0);
        check("async_rst_cfg0_ready", cfg0.ready, 1'b0);
        check("async_rst_cfg1_ready", cfg1.ready, 1'b0);
        @(negedge clk);
        drive_idle();
        exp_q.delete();
        prio_m = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // After reset, a simultaneous request must be granted to requester 0 first.
        add_burst(0, 1, 2);
        add_burst(1, 1, 2);
        run_round(100, 100);
        check("post_rst_cfg0_hs", cfg_hs0, 1);
        check("post_rst_cfg1_hs", cfg_hs1, 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
